// File: rtl/imem_pkg.sv
// Shared instruction-memory geometry and loader state encoding.
// Used by imem_loader and by the instruction memory itself.
package imem_pkg;

  localparam int IMEM_DEPTH  = 32;
  localparam int IMEM_ADDR_W = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_CHK,
    S_DONE
  } loader_state_e;

endpackage

// File: rtl/word_assembler.sv
// Collects four stream bytes into a 32-bit word, least significant lane first.
// word_full is high for the cycle after the fourth byte lands.
module word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic [1:0]  byte_cnt,
  output logic        word_full
);

  logic [31:0] word_reg;
  logic [31:0] word_next;
  logic [1:0]  cnt_reg;
  logic        full_reg;

  // Each lane only loads when the byte counter points at it.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign word_next[gi*8 +: 8] = (shift_en && (cnt_reg == 2'(gi))) ? byte_in
                                                                     : word_reg[gi*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      word_reg <= '0;
      cnt_reg  <= '0;
      full_reg <= 1'b0;
    end else begin
      word_reg <= word_next;
      full_reg <= shift_en && (cnt_reg == 2'd3);
      if (shift_en) begin
        cnt_reg <= cnt_reg + 2'd1;
      end
    end
  end

  assign word      = word_reg;
  assign byte_cnt  = cnt_reg;
  assign word_full = full_reg;

endmodule

// File: rtl/imem_loader.sv
// Loads the instruction memory from a length-prefixed little-endian byte stream,
// holding the core in reset while loading. Optional IMEM_LOADER_CHKSUM_EN adds a trailing XOR checksum byte.
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_rst
);

  localparam logic [8:0] DEPTH_LIM = 9'(DEPTH);

  loader_state_e     state_reg, state_next;
  logic [7:0]        n_reg, n_next;
  logic [ADDR_W-1:0] word_cnt_reg, word_cnt_next;
  logic              err_reg, err_next;

  logic              start_ok;
  logic              shift_en;
  logic              word_last;
  logic [31:0]       word;
  logic [1:0]        byte_cnt;
  logic              word_full;

  assign start_ok  = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));
  assign shift_en  = (state_reg == S_DATA) && byte_valid;
  assign word_last = ((8'(word_cnt_reg) + 8'd1) == n_reg);

  word_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clr       (start_ok),
    .shift_en  (shift_en),
    .byte_in   (byte_in),
    .word      (word),
    .byte_cnt  (byte_cnt),
    .word_full (word_full)
  );

`ifdef IMEM_LOADER_CHKSUM_EN
  logic [7:0] chk_reg;

  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      chk_reg <= '0;
    end else if (shift_en) begin
      chk_reg <= chk_reg ^ byte_in;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      n_reg        <= '0;
      word_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      n_reg        <= n_next;
      word_cnt_reg <= word_cnt_next;
      err_reg      <= err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    n_next        = n_reg;
    word_cnt_next = word_cnt_reg;
    err_next      = err_reg;
    byte_ready    = 1'b0;
    wr_en         = 1'b0;
    wr_addr       = '0;
    wr_data       = '0;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_next    = S_LEN;
          n_next        = '0;
          word_cnt_next = '0;
          err_next      = 1'b0;
        end
      end
      S_LEN: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          n_next = byte_in;
          if ((byte_in == 8'd0) || ({1'b0, byte_in} > DEPTH_LIM)) begin
            err_next   = 1'b1;
            state_next = S_DONE;
          end else begin
            state_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        byte_ready = 1'b1;
        if (byte_valid && (byte_cnt == 2'd3)) begin
          state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        wr_en         = word_full;
        wr_addr       = word_cnt_reg;
        wr_data       = word;
        word_cnt_next = word_cnt_reg + ADDR_W'(1);
        if (word_last) begin
`ifdef IMEM_LOADER_CHKSUM_EN
          state_next = S_CHK;
`else
          state_next = S_DONE;
`endif
        end else begin
          state_next = S_DATA;
        end
      end
      S_CHK: begin
`ifdef IMEM_LOADER_CHKSUM_EN
        byte_ready = 1'b1;
        if (byte_valid) begin
          if (byte_in != chk_reg) begin
            err_next = 1'b1;
          end
          state_next = S_DONE;
        end
`else
        state_next = S_DONE;
`endif
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign busy    = (state_reg != S_IDLE) && (state_reg != S_DONE);
  assign done    = (state_reg == S_DONE);
  assign err     = err_reg;
  assign cpu_rst = rst | busy;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of byte streams plus hand-written
// reset/boundary sequences; expected writes go through a scoreboard queue.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        err;
  logic        cpu_rst;

  imem_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .cpu_rst    (cpu_rst)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    string      name;
    int         nb;
    logic [7:0] b [16];
    bit         stall;
    bit         mid_start;
    int         delta;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  int         writes_seen = 0;
  logic       prev_wr = 1'b0;
  wr_t        exp_q[$];
  logic [7:0] stream_q[$];
  vec_t       vecs[7];

  // Write monitor: pops the scoreboard on every strobe.
  always @(negedge clk) begin
    wr_t e;
    if (wr_en === 1'b1) begin
      writes_seen++;
      checks++;
      if (prev_wr === 1'b1) begin
        errors++;
        $display("FAIL wr_en_single: got wr_en high two cycles in a row, required one cycle");
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=%08h, required no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if (wr_addr !== e.addr || wr_data !== e.data) begin
          errors++;
          $display("FAIL write: got addr=%0d data=%08h, required addr=%0d data=%08h",
                   wr_addr, wr_data, e.addr, e.data);
        end else begin
          $display("write addr=%0d data=%08h", wr_addr, wr_data);
        end
      end
    end
    prev_wr = wr_en;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic set_vec(input int idx, input string name, input int nb, input logic [127:0] lit,
                         input bit stall, input bit mid_start, input int delta);
    vecs[idx].name      = name;
    vecs[idx].nb        = nb;
    vecs[idx].stall     = stall;
    vecs[idx].mid_start = mid_start;
    vecs[idx].delta     = delta;
    for (int i = 0; i < 16; i++) vecs[idx].b[i] = lit[127-8*i -: 8];
  endtask

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic send_byte(input logic [7:0] b, input bit stall);
    int guard;
    if (stall) begin
      byte_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    byte_in    = b;
    byte_valid = 1'b1;
    guard      = 0;
    while (byte_ready !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (byte_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: got byte_ready=%b, required 1 within 40 cycles", byte_ready);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_stream(input string name, input bit stall, input bit mid_start, input int delta);
    int         n;
    int         guard;
    int         base;
    int         exp_writes;
    bit         legal;
    bit         exp_err;
    logic [7:0] x;
    logic [31:0] d;
    n     = int'(stream_q[0]);
    legal = (n >= 1) && (n <= 32);
    x     = 8'h00;
    if (legal) begin
      for (int w = 0; w < n; w++) begin
        d = {stream_q[4*w+4], stream_q[4*w+3], stream_q[4*w+2], stream_q[4*w+1]};
        exp_q.push_back('{addr: 5'(w), data: d});
        x = x ^ d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24];
      end
    end
`ifdef IMEM_LOADER_CHKSUM_EN
    if (legal) stream_q.push_back(x ^ 8'(delta));
    exp_err = !legal || (delta != 0);
`else
    exp_err = !legal;
`endif
    exp_writes = legal ? n : 0;
    base       = writes_seen;
    pulse_start();
    check({name, "_busy_after_start"}, 32'(busy), 32'd1);
    check({name, "_cpu_rst_loading"}, 32'(cpu_rst), 32'd1);
    check({name, "_done_cleared"}, 32'(done), 32'd0);
    for (int i = 0; i < stream_q.size(); i++) begin
      if (mid_start && i == 3) begin
        byte_valid = 1'b0;
        pulse_start();
      end
      send_byte(stream_q[i], stall);
    end
    byte_valid = 1'b0;
    guard = 0;
    while (done !== 1'b1 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_err"}, 32'(err), 32'(exp_err));
    check({name, "_busy_low"}, 32'(busy), 32'd0);
    check({name, "_cpu_rst_low"}, 32'(cpu_rst), 32'd0);
    check({name, "_write_count"}, 32'(writes_seen - base), 32'(exp_writes));
    check({name, "_scoreboard_empty"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    $display("stream %s: done=%0b err=%0b writes=%0d", name, done, err, writes_seen - base);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    check({tag, "_wr_data"}, wr_data, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    int base;

    set_vec(0, "nominal",     9, 128'h02130000009300100000000000000000, 1'b0, 1'b0, 0);
    set_vec(1, "stalls",      9, 128'h02130000009300100000000000000000, 1'b1, 1'b0, 0);
    set_vec(2, "len_zero",    1, 128'h00000000000000000000000000000000, 1'b0, 1'b0, 0);
    set_vec(3, "len_21",      1, 128'h21000000000000000000000000000000, 1'b0, 1'b0, 0);
    set_vec(4, "chk_bad",     9, 128'h02130000009300100000000000000000, 1'b0, 1'b0, 1);
    set_vec(5, "three_words", 13, 128'h0378563412efbeadde01020304000000, 1'b1, 1'b0, 0);
    set_vec(6, "start_busy",  9, 128'h02130000009300100000000000000000, 1'b0, 1'b1, 0);

    rst        = 1'b1;
    start      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_cpu_rst", 32'(cpu_rst), 32'd1);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);
    check("idle_cpu_rst", 32'(cpu_rst), 32'd0);
    check_reset_values("idle");

    for (int v = 0; v < 7; v++) begin
      stream_q.delete();
      for (int j = 0; j < vecs[v].nb; j++) stream_q.push_back(vecs[v].b[j]);
      run_stream(vecs[v].name, vecs[v].stall, vecs[v].mid_start, vecs[v].delta);
    end

    // A stray byte in DONE must be refused and cause no write.
    base       = writes_seen;
    byte_in    = 8'h5a;
    byte_valid = 1'b1;
    @(negedge clk);
    check("stray_byte_ready", 32'(byte_ready), 32'd0);
    @(negedge clk);
    byte_valid = 1'b0;
    check("stray_done_held", 32'(done), 32'd1);
    check("stray_no_write", 32'(writes_seen - base), 32'd0);

    // Reset after 6 data bytes: only word 0 was written.
    exp_q.push_back('{addr: 5'd0, data: 32'h44332211});
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    byte_valid = 1'b0;
    check("midrst_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_cpu_rst", 32'(cpu_rst), 32'd1);
    check_reset_values("midrst");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_cpu_rst_low", 32'(cpu_rst), 32'd0);
    check("midrst_idle_busy", 32'(busy), 32'd0);
    check("midrst_scoreboard", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    $display("stream mid_reset: aborted after word 0");

    stream_q.delete();
    stream_q.push_back(8'h01);
    stream_q.push_back(8'h13);
    stream_q.push_back(8'h00);
    stream_q.push_back(8'h00);
    stream_q.push_back(8'h00);
    run_stream("after_reset", 1'b0, 1'b0, 0);

    // Full-depth load: N equals DEPTH, last address is 31.
    stream_q.delete();
    stream_q.push_back(8'h20);
    for (int i = 0; i < 128; i++) stream_q.push_back(8'($urandom_range(0, 255)));
    run_stream("full_depth", 1'b0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
